// File: rtl/song_recorder.sv
// song_recorder: captures the live key vector as (key, duration) entries in a
// small note RAM while writing is high, then replays the stored list as a
// looping key stream for the music-box player.
module song_recorder #(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 2500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              writing,
  input  logic [15:0]       SW,
  input  logic              play_en,
  input  logic              clear,
  output logic [15:0]       signal,
  output logic [ADDR_W:0]   song_len,
  output logic              full,
  output logic              recording
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int ENT_W = 16 + DUR_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [ADDR_W:0]  LEN_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_FULL, S_PLAY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   len_nxt, len_inc;
  logic              full_nxt;
  logic [15:0]       cur_key, key_nxt;
  logic [DUR_W-1:0]  dur, dur_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              tick;
  logic [ADDR_W-1:0] rd_ptr, rd_nxt, nxt_ptr, raddr;
  logic [ADDR_W:0]   rd_inc;
  logic              primed, primed_nxt;
  logic [15:0]       play_key, pkey_nxt;
  logic [DUR_W-1:0]  play_rem, prem_nxt;
  logic              we;
  logic [DUR_W-1:0]  wr_dur;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  ent_p1;

  assign tick    = (cnt == CNT_LAST);
  assign len_inc = song_len + 1'b1;
  assign rd_inc  = {1'b0, rd_ptr} + 1'b1;
  assign nxt_ptr = (rd_inc >= song_len) ? '0 : rd_inc[ADDR_W-1:0];
  // Until the first note is loaded the read port sits on entry 0; afterwards
  // it prefetches the entry following the one being played.
  assign raddr   = (state == S_PLAY && primed) ? nxt_ptr : '0;

  assign signal    = (state == S_PLAY && primed && play_en) ? play_key : 16'h0000;
  assign recording = (state == S_REC);

  // Next-state, record-entry and playback-sequencing decisions
  always_comb begin
    state_nxt  = state;
    len_nxt    = song_len;
    full_nxt   = full;
    key_nxt    = cur_key;
    dur_nxt    = dur;
    cnt_nxt    = cnt;
    rd_nxt     = rd_ptr;
    primed_nxt = primed;
    pkey_nxt   = play_key;
    prem_nxt   = play_rem;
    we         = 1'b0;
    wr_dur     = dur;
    if (clear) begin
      state_nxt  = S_IDLE;
      len_nxt    = '0;
      full_nxt   = 1'b0;
      rd_nxt     = '0;
      primed_nxt = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (writing) begin
            state_nxt = S_REC;
            len_nxt   = '0;
            full_nxt  = 1'b0;
            key_nxt   = SW;
            dur_nxt   = '0;
            // The key was already on SW during the clk that sampled it, so
            // that clk is count 0 of the first tick period.
            cnt_nxt   = CNT_W'(1);
          end else if (play_en && song_len != '0) begin
            state_nxt  = S_PLAY;
            rd_nxt     = '0;
            primed_nxt = 1'b0;
          end
        end
        S_REC: begin
          if (!writing) begin
            we        = (dur != '0);
            state_nxt = S_IDLE;
          end else if (SW != cur_key) begin
            // A key released before its first tick leaves no entry.
            we      = (dur != '0);
            key_nxt = SW;
            dur_nxt = '0;
            cnt_nxt = CNT_W'(1);
          end else if (tick) begin
            cnt_nxt = '0;
            if (dur == DUR_MAX - 1'b1) begin
              // Long notes are split into maximum-length entries.
              we      = 1'b1;
              wr_dur  = DUR_MAX;
              dur_nxt = '0;
            end else begin
              dur_nxt = dur + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
          if (we) begin
            len_nxt = len_inc;
            if (len_inc == LEN_FULL) begin
              full_nxt = 1'b1;
              if (writing) state_nxt = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!writing) state_nxt = S_IDLE;
        end
        S_PLAY: begin
          if (writing) begin
            state_nxt  = S_REC;
            len_nxt    = '0;
            full_nxt   = 1'b0;
            key_nxt    = SW;
            dur_nxt    = '0;
            cnt_nxt    = CNT_W'(1);
            primed_nxt = 1'b0;
          end else if (play_en) begin
            if (!primed || (tick && play_rem == DUR_W'(1))) begin
              // Switch to the prefetched entry on the clk the old note ends.
              pkey_nxt   = ent_p1[ENT_W-1:DUR_W];
              prem_nxt   = ent_p1[DUR_W-1:0];
              cnt_nxt    = '0;
              primed_nxt = 1'b1;
              rd_nxt     = primed ? nxt_ptr : rd_ptr;
            end else if (tick) begin
              prem_nxt = play_rem - 1'b1;
              cnt_nxt  = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Control state, counters and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      song_len <= '0;
      full     <= 1'b0;
      dur      <= '0;
      cnt      <= '0;
      rd_ptr   <= '0;
      primed   <= 1'b0;
      play_rem <= '0;
    end else begin
      state    <= state_nxt;
      song_len <= len_nxt;
      full     <= full_nxt;
      dur      <= dur_nxt;
      cnt      <= cnt_nxt;
      rd_ptr   <= rd_nxt;
      primed   <= primed_nxt;
      play_rem <= prem_nxt;
    end
  end

  // Key holding registers (qualified by state, so no reset needed)
  always_ff @(posedge clk) begin
    cur_key  <= key_nxt;
    play_key <= pkey_nxt;
  end

  // Note RAM: one write port at song_len, one synchronous read port
  always_ff @(posedge clk) begin
    if (we) mem[song_len[ADDR_W-1:0]] <= {cur_key, wr_dur};
    ent_p1 <= mem[raddr];
  end

endmodule

// File: doc/song_recorder.md
Name: song_recorder

Overview:
Writing-mode companion to the music-box player. It records the live 16-bit key vector (SW) as a list of (key, duration) entries in an internal note RAM while `writing` is high. It then replays that list as the 16-bit `signal` stream consumed by the music-box player. It is the producer end of the `signal` interface that the player reads in music-box mode.

Parameters:
DEPTH, 64, number of note entries in RAM.
ADDR_W, 6, log2(DEPTH).
DUR_W, 8, duration field width, in ticks.
TICK_DIV, 2500000, clk cycles per duration tick (must be >= 2).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
writing  in  1  level; high = record mode (from mode control)
SW  in  16  live key vector (bit i = key i pressed)
play_en  in  1  level; high = playback running, low = paused
clear  in  1  single-clk pulse; erase song
signal  out  16  key vector being replayed; 0 when not playing
song_len  out  ADDR_W+1  number of valid entries, 0..DEPTH
full  out  1  RAM full during/after recording
recording  out  1  high in state REC

Behaviour:
- Reset values: state IDLE; signal=0, song_len=0, full=0, recording=0; all pointers and counters 0. RAM contents don't care.
- Entry format: {key[15:0], dur[DUR_W-1:0]}. Note RAM is synchronous-read with one write port and one read port.
- Tick: a free counter 0..TICK_DIV-1 pulses `tick` on the terminal count. The counter restarts at 0 whenever a new record entry or a new playback note begins.
- States: IDLE, REC, FULL, PLAY.
- clear has top priority in every state: next clk goes to IDLE with song_len=0, full=0, signal=0.
- IDLE transitions:
  - writing=1 -> REC. On that clk: song_len=0, wr_ptr=0, cur_key=SW, dur=0, full=0. Recording always overwrites the previous song.
  - else play_en=1 and song_len!=0 -> PLAY with rd_ptr=0.
  - signal=0 in IDLE.
- REC, each clk, in priority order:
  1. writing=0: flush {cur_key,dur} if dur!=0 (song_len++), then -> IDLE.
  2. SW!=cur_key: if dur!=0, write {cur_key,dur} and song_len++. cur_key=SW, dur=0, tick counter restarts. If SW changes before the first tick (dur=0), the old key is discarded with no entry (glitch rejection).
  3. tick: dur++. If dur reaches 2^DUR_W-1, write {cur_key,max}, song_len++, dur=0, same key continues (long notes split).
  - A key change coincident with a tick follows rule 2; that tick is not counted.
  - Any write that makes song_len==DEPTH -> FULL.
  - Silence (SW=0) is recorded as an ordinary rest entry.
- FULL: full=1; SW ignored; writing=0 -> IDLE (full stays 1 until the next REC or clear).
- PLAY:
  - signal = key of entry rd_ptr.
  - Note i occupies exactly dur_i*TICK_DIV clks of `signal`, with no gap between notes. The implementation prefetches the next entry to hide RAM read latency.
  - After the last entry, rd_ptr wraps to 0 (loop). With song_len=1 the output is a constant key.
  - play_en=0: tick and note counters freeze, signal=0. Resuming continues mid-note with the remaining time.
  - writing=1 -> REC (same entry actions as from IDLE).
- recording = (state==REC). song_len is stable, never decremented except by clear or REC entry.
- Reset asserted mid-record discards the partial song (song_len=0).

Test Plan:
- Reset check: hold rst_n=0, toggle all inputs -> signal=0, song_len=0, full=0, recording=0. After release, state is IDLE.
- Basic record (TICK_DIV=4): writing=1, SW=0x0001 for 12 clks, then SW=0x0004 for 8 clks, then writing=0 -> RAM holds (0x0001,3),(0x0004,2); song_len=2.
- Playback from the previous song, play_en=1 -> signal=0x0001 for exactly 12 clks, then 0x0004 for 8 clks, then loops to 0x0001. Dropping play_en for 5 clks mid-note gives signal=0 and extends the total by exactly 5 clks.
- Saturation (DUR_W=2, TICK_DIV=4): hold 0x0080 for 20 clks -> entries (0x0080,3),(0x0080,2); song_len=2.
- Full (DEPTH=4): 6 distinct keys, 8 clks each -> full=1 and state FULL after the 4th write; song_len=4; further SW changes are ignored.
- Glitch and clear: a 2-clk SW pulse (TICK_DIV=4) inside REC creates no entry. A clear pulse during PLAY -> next clk signal=0, song_len=0, state IDLE.
